microc_mc: RTL
==============

// Module: microc_mc
// PURPOSE
//  Parametrised multicycle successor of the single-cycle microcontroller: FETCH/EXEC control FSM, data width DW,
//  optional return-address stack, handshaked output port and sampled input port. Sits between external program ROM
//  (combinational read) and the board I/O; carries its own control unit (no Opcode/control ports exported).
// PARAMETERS
//  DW           8   data/register width (>=8); 8-bit immediates zero-extended to DW
//  PCW          10  program counter width (<=10); jump field [9:0] truncated to PCW bits
//  STACK_DEPTH  8   return-address stack entries (>=2, power of 2); used only with MICROC_CALLRET_EN
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset      in   1      synchronous, active-high
//  pc         out  PCW    program address to ROM
//  instr      in   16     ROM data for pc, valid same cycle
//  in_data    in   DW     input port, sampled by IN in EXEC cycle
//  out_data   out  DW     output port data, registered
//  out_valid  out  1      out_data valid; held until out_ready
//  out_ready  in   1      consumer accepts when out_valid&out_ready
//  z          out  1      zero flag
//  err        out  1      sticky stack fault; core halted
// BEHAVIOUR
//  Reset: pc=0, IR=0, z=0, out_data=0, out_valid=0, err=0, sp=0, state=FETCH. Regs R1..R15 not reset; R0 reads 0, writes dropped.
//  States: FETCH -> EXEC -> FETCH (2 cycles/instr); EXEC(OUT) -> OUTW; OUTW -> FETCH on out_ready; stack fault -> HALT (exit only by reset).
//  FETCH: IR<=instr. EXEC: decode IR[15:12], update regs/z/pc. pc+1 wraps mod 2^PCW.
//  Encoding: 1ooo ALU rd[3:0]=ra[11:8] op rb[7:4]; 0000 LI rd[3:0]=imm[11:4]; 0001 J; 0010 JZ; 0011 JNZ (addr [9:0]);
//   0100 CALL addr; 0101 RET; 0110 OUT ra[11:8]; 0111 IN rd[3:0]. Unlisted codes: none (all 16 defined).
//  ALU ooo: 000 A, 001 ~A, 010 A+B, 011 A-B, 100 A&B, 101 A|B, 110 -A, 111 -B; result mod 2^DW, carry dropped.
//  z written only by ALU ops (z = result==0), incl. when rd=R0; LI/IN/jumps leave z unchanged.
//  OUT: in EXEC, out_data<=R[ra], out_valid<=1, go OUTW; pc advances to pc+1 on the handshake cycle; out_valid<=0 same edge.
//   out_ready high in EXEC has no effect (valid not yet visible); min OUT duration 3 cycles.
//  CALL: push pc+1, pc<=addr. RET: pop into pc. Push with sp==STACK_DEPTH or pop with sp==0 -> err<=1, HALT, pc frozen, no reg writes.
//  HALT: out_valid=0, no further fetch; reset mid any state (incl. OUTW, HALT) returns to reset values next edge.
// CONFIGURATION
//  MICROC_CALLRET_EN defined: stack + CALL/RET as above.
//  Undefined: no stack logic; CALL and RET execute as NOP (pc+1); err tied 0; STACK_DEPTH ignored; HALT unreachable.
// STRUCTURE
//  Package microc_pkg: opcode localparams, ALU op codes, state encoding (FETCH, EXEC, OUTW, HALT), instr field slices.
//  Sub-module microc_stack (#(PCW, STACK_DEPTH)): push/pop/full/empty, top read combinational; instantiated only under macro.
//  Regfile (16xDW, 2R1W, R0=0) and ALU inline in microc_mc.
// TESTING
//  1 Reset held 2 cycles then released -> pc=0, z=0, out_valid=0, err=0; instr at 0 latched on first edge.
//  2 LI R1,5; LI R2,3; ALU 011 R3=R1-R2; OUT R3, out_ready=0 for 4 cycles -> out_valid=1, out_data=2, pc stable; ready=1 -> pc+1, valid 0.
//  3 ALU 011 R4=R1-R1 -> z=1; LI R5,0 -> z still 1; JZ 0x020 -> pc=0x020 after EXEC; JNZ 0x040 -> pc=0x021.
//  4 DW=16: LI R1,0xFF; ALU 010 R2=R1+R1 -> R2=0x01FE, z=0; ALU 110 R3=-R0 -> z=1.
//  5 MICROC_CALLRET_EN, STACK_DEPTH=4: 4 nested CALLs then RETs return to each pc+1; 5th nested CALL -> err=1, pc frozen; RET with sp=0 also -> err=1.
//  6 Reset asserted in OUTW -> out_valid=0, pc=0 next edge; without macro CALL 0x100 at pc=5 -> pc=6, err=0.

Source files
------------

// File: rtl/microc_pkg.sv
// Shared definitions for the multicycle microcontroller core.
// Holds the control-state encoding, opcode and ALU operation codes, and
// helper functions that slice the fixed 16-bit instruction fields.
// Optional feature macro used by the core: MICROC_CALLRET_EN.
package microc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_OUTW  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Opcodes with IR[15]==0; IR[15]==1 selects an ALU operation in IR[14:12]
  localparam logic [3:0] OPC_LI   = 4'h0;
  localparam logic [3:0] OPC_J    = 4'h1;
  localparam logic [3:0] OPC_JZ   = 4'h2;
  localparam logic [3:0] OPC_JNZ  = 4'h3;
  localparam logic [3:0] OPC_CALL = 4'h4;
  localparam logic [3:0] OPC_RET  = 4'h5;
  localparam logic [3:0] OPC_OUT  = 4'h6;
  localparam logic [3:0] OPC_IN   = 4'h7;

  localparam logic [2:0] ALU_A    = 3'd0;
  localparam logic [2:0] ALU_NOTA = 3'd1;
  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_SUB  = 3'd3;
  localparam logic [2:0] ALU_AND  = 3'd4;
  localparam logic [2:0] ALU_OR   = 3'd5;
  localparam logic [2:0] ALU_NEGA = 3'd6;
  localparam logic [2:0] ALU_NEGB = 3'd7;

  function automatic logic [3:0] f_opc(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  function automatic logic [2:0] f_aluop(input logic [15:0] ir);
    return ir[14:12];
  endfunction

  function automatic logic [3:0] f_ra(input logic [15:0] ir);
    return ir[11:8];
  endfunction

  function automatic logic [3:0] f_rb(input logic [15:0] ir);
    return ir[7:4];
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] ir);
    return ir[3:0];
  endfunction

  function automatic logic [7:0] f_imm(input logic [15:0] ir);
    return ir[11:4];
  endfunction

  function automatic logic [9:0] f_addr(input logic [15:0] ir);
    return ir[9:0];
  endfunction

endpackage

// File: rtl/microc_stack.sv
// Return-address stack for CALL/RET.
// Ports: clk/reset (sync, active-high), push/pop requests, din (address to
// push), top (combinational read of the most recent entry), full, empty.
// Push when full and pop when empty are ignored; the core turns them into a fault.
module microc_stack #(
  parameter int PCW         = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] din,
  output logic [PCW-1:0] top,
  output logic           full,
  output logic           empty
);
  import microc_pkg::*;

  localparam int AW = $clog2(STACK_DEPTH);

  logic [AW:0]    sp_r;
  logic [PCW-1:0] mem_r [STACK_DEPTH];

  assign full  = (sp_r == (AW+1)'(STACK_DEPTH));
  assign empty = (sp_r == {(AW+1){1'b0}});
  // Index wraps naturally; only meaningful when not empty
  assign top   = mem_r[sp_r[AW-1:0] - AW'(1)];

  // Stack pointer: counts valid entries
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_r <= {(AW+1){1'b0}};
    end else if (push && !full) begin
      sp_r <= sp_r + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp_r <= sp_r - (AW+1)'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage; contents need no reset because sp gates every read
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[sp_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/microc_mc.sv
// Multicycle microcontroller core: FETCH/EXEC control FSM, 16xDW register
// file (R0 reads zero), inline ALU, handshaked output port and sampled input.
// Ports: clk, reset (sync, active-high); pc/instr to a combinational ROM;
// in_data sampled by IN; out_data/out_valid/out_ready output handshake;
// z zero flag; err sticky stack fault (core halted).
// Macro MICROC_CALLRET_EN enables the return-address stack and CALL/RET;
// without it CALL/RET are NOPs and err stays 0.
module microc_mc #(
  parameter int DW          = 8,
  parameter int PCW         = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  output logic [PCW-1:0] pc,
  input  logic [15:0]    instr,
  input  logic [DW-1:0]  in_data,
  output logic [DW-1:0]  out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           z,
  output logic           err
);
  import microc_pkg::*;

  state_t         state_r, state_nxt_s;
  logic [PCW-1:0] pc_r, pc_nxt_s, pc_inc_s, jmp_s;
  logic [15:0]    ir_r, ir_nxt_s;
  logic           z_r, z_nxt_s, err_r, err_nxt_s, out_valid_r, out_valid_nxt_s;
  logic [DW-1:0]  out_data_r, out_data_nxt_s;
  logic [DW-1:0]  rf_r [16];
  logic [DW-1:0]  a_s, b_s, alu_s, rf_wdata_s;
  logic           rf_we_s;
  logic [3:0]     rf_waddr_s;

  assign pc        = pc_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign z         = z_r;
  assign err       = err_r;

  assign pc_inc_s = pc_r + PCW'(1);
  assign jmp_s    = PCW'(f_addr(ir_r));
  assign a_s      = (f_ra(ir_r) == 4'd0) ? {DW{1'b0}} : rf_r[f_ra(ir_r)];
  assign b_s      = (f_rb(ir_r) == 4'd0) ? {DW{1'b0}} : rf_r[f_rb(ir_r)];

`ifdef MICROC_CALLRET_EN
  logic           push_s, pop_s, full_s, empty_s;
  logic [PCW-1:0] stack_top_s;

  microc_stack #(.PCW(PCW), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (pc_inc_s),
    .top   (stack_top_s),
    .full  (full_s),
    .empty (empty_s)
  );
`endif

  // ALU: result wraps mod 2^DW, carry discarded
  always_comb begin
    alu_s = a_s;
    case (f_aluop(ir_r))
      ALU_A:    alu_s = a_s;
      ALU_NOTA: alu_s = ~a_s;
      ALU_ADD:  alu_s = a_s + b_s;
      ALU_SUB:  alu_s = a_s - b_s;
      ALU_AND:  alu_s = a_s & b_s;
      ALU_OR:   alu_s = a_s | b_s;
      ALU_NEGA: alu_s = {DW{1'b0}} - a_s;
      ALU_NEGB: alu_s = {DW{1'b0}} - b_s;
      default:  alu_s = a_s;
    endcase
  end

  // Control FSM next-state, datapath next values and register-file write
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    ir_nxt_s        = ir_r;
    z_nxt_s         = z_r;
    err_nxt_s       = err_r;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    rf_we_s         = 1'b0;
    rf_waddr_s      = f_rd(ir_r);
    rf_wdata_s      = alu_s;
`ifdef MICROC_CALLRET_EN
    push_s          = 1'b0;
    pop_s           = 1'b0;
`endif
    case (state_r)
      ST_FETCH: begin
        ir_nxt_s    = instr;
        state_nxt_s = ST_EXEC;
      end
      ST_EXEC: begin
        state_nxt_s = ST_FETCH;
        pc_nxt_s    = pc_inc_s;
        if (ir_r[15]) begin
          rf_we_s = 1'b1;
          z_nxt_s = (alu_s == {DW{1'b0}});
        end else begin
          case (f_opc(ir_r))
            OPC_LI: begin
              rf_we_s    = 1'b1;
              rf_wdata_s = DW'(f_imm(ir_r));
            end
            OPC_J:   pc_nxt_s = jmp_s;
            OPC_JZ:  pc_nxt_s = z_r ? jmp_s : pc_inc_s;
            OPC_JNZ: pc_nxt_s = z_r ? pc_inc_s : jmp_s;
`ifdef MICROC_CALLRET_EN
            OPC_CALL: begin
              if (full_s) begin
                err_nxt_s   = 1'b1;
                state_nxt_s = ST_HALT;
                pc_nxt_s    = pc_r;
              end else begin
                push_s   = 1'b1;
                pc_nxt_s = jmp_s;
              end
            end
            OPC_RET: begin
              if (empty_s) begin
                err_nxt_s   = 1'b1;
                state_nxt_s = ST_HALT;
                pc_nxt_s    = pc_r;
              end else begin
                pop_s    = 1'b1;
                pc_nxt_s = stack_top_s;
              end
            end
`else
            OPC_CALL: pc_nxt_s = pc_inc_s;
            OPC_RET:  pc_nxt_s = pc_inc_s;
`endif
            OPC_OUT: begin
              // pc advances only on the handshake cycle in OUTW
              out_data_nxt_s  = a_s;
              out_valid_nxt_s = 1'b1;
              state_nxt_s     = ST_OUTW;
              pc_nxt_s        = pc_r;
            end
            OPC_IN: begin
              rf_we_s    = 1'b1;
              rf_wdata_s = in_data;
            end
            default: pc_nxt_s = pc_inc_s;
          endcase
        end
      end
      ST_OUTW: begin
        if (out_ready) begin
          out_valid_nxt_s = 1'b0;
          pc_nxt_s        = pc_inc_s;
          state_nxt_s     = ST_FETCH;
        end else begin
          state_nxt_s = ST_OUTW;
        end
      end
      ST_HALT: begin
        state_nxt_s     = ST_HALT;
        out_valid_nxt_s = 1'b0;
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_FETCH;
      pc_r        <= {PCW{1'b0}};
      ir_r        <= 16'h0000;
      z_r         <= 1'b0;
      err_r       <= 1'b0;
      out_data_r  <= {DW{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      ir_r        <= ir_nxt_s;
      z_r         <= z_nxt_s;
      err_r       <= err_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
    end
  end

  // Register file write port; R0 writes are dropped, R1..R15 have no reset
  always_ff @(posedge clk) begin
    if (rf_we_s && (rf_waddr_s != 4'd0)) begin
      rf_r[rf_waddr_s] <= rf_wdata_s;
    end
  end

endmodule
